// File: rtl/fu_issue_buffer.sv
// fu_issue_buffer: age-ordered issue FIFO between RS select and one FU class.
// Optional same-cycle bypass when empty: define FU_ISSUE_BUF_BYPASS_EN.
module fu_issue_buffer #(
    parameter int NUM_IN = 2,
    parameter int NUM_FU = 3,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              squash,
    input  logic [NUM_IN-1:0]                 in_valid,
    input  logic [NUM_IN-1:0][DATA_W-1:0]     in_data,
    output logic [$clog2(DEPTH+1)-1:0]        free_slots,
    input  logic [NUM_FU-1:0]                 fu_avail,
    output logic [NUM_FU-1:0]                 out_valid,
    output logic [NUM_FU-1:0][DATA_W-1:0]     out_data,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              overflow
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_ovf;

    logic [CW-1:0]     w_free;
    logic [CW-1:0]     w_k;
    logic [CW-1:0]     w_n;
    logic [PW-1:0]     w_ridx;
    logic [PW-1:0]     w_widx;
    logic [NUM_IN-1:0] w_used;
    logic [DEPTH-1:0]  w_deq;
    logic [DEPTH-1:0]  w_wen;
    logic [DATA_W-1:0] w_wdata [DEPTH];
    logic              w_ovf;
`ifdef FU_ISSUE_BUF_BYPASS_EN
    logic              w_found;
`endif

    assign free_slots = w_free;
    assign count      = r_count;
    assign overflow   = r_ovf;

    // Map oldest entries (or bypassed lanes when empty) onto available FUs
    always_comb begin
        w_k       = '0;
        w_deq     = '0;
        w_ridx    = '0;
        w_used    = '0;
        out_valid = '0;
        out_data  = '0;
`ifdef FU_ISSUE_BUF_BYPASS_EN
        w_found   = 1'b0;
`endif
        if (!squash) begin
            for (int i = 0; i < NUM_FU; i++) begin
                w_ridx = r_head + w_k[PW-1:0];
                if (fu_avail[i] && (w_k < r_count) && r_vld[w_ridx]) begin
                    out_valid[i]  = 1'b1;
                    out_data[i]   = r_mem[w_ridx];
                    w_deq[w_ridx] = 1'b1;
                    w_k           = w_k + CW'(1);
                end
            end
`ifdef FU_ISSUE_BUF_BYPASS_EN
            if (r_count == '0) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    w_found = 1'b0;
                    if (fu_avail[i]) begin
                        for (int l = 0; l < NUM_IN; l++) begin
                            if (!w_found && in_valid[l] && !w_used[l]) begin
                                w_found      = 1'b1;
                                w_used[l]    = 1'b1;
                                out_valid[i] = 1'b1;
                                out_data[i]  = in_data[l];
                            end
                        end
                    end
                end
            end
`endif
        end
    end

    // Compact remaining valid lanes into free slots at tail; flag any drops
    always_comb begin
        w_free = DEPTH_C - r_count;
        w_n    = '0;
        w_ovf  = 1'b0;
        w_wen  = '0;
        w_widx = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_wdata[e] = '0;
        end
        for (int l = 0; l < NUM_IN; l++) begin
            if (in_valid[l] && !w_used[l]) begin
                if (w_n < w_free) begin
                    w_widx          = r_tail + w_n[PW-1:0];
                    w_wen[w_widx]   = 1'b1;
                    w_wdata[w_widx] = in_data[l];
                    w_n             = w_n + CW'(1);
                end else begin
                    w_ovf = 1'b1;
                end
            end
        end
    end

    // Pointer, occupancy, valid-bit and sticky overflow state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
            if (squash) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_vld   <= '0;
            end else begin
                r_head  <= r_head + w_k[PW-1:0];
                r_tail  <= r_tail + w_n[PW-1:0];
                r_count <= r_count + w_n - w_k;
                r_vld   <= (r_vld & ~w_deq) | w_wen;
            end
        end
    end

    // Payload storage; contents are qualified by r_vld so no reset needed
    always_ff @(posedge clock) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_wen[e] && !squash) begin
                r_mem[e] <= w_wdata[e];
            end
        end
    end

endmodule

// File: tb/tb_fu_issue_buffer.sv
// tb_fu_issue_buffer: randomized scoreboard bench for fu_issue_buffer.
// Reference model is a plain queue of payloads in age order.
module tb_fu_issue_buffer;

    logic             clk;
    logic             rst_n;
    logic             squash;
    logic [1:0]       in_valid;
    logic [1:0][63:0] in_data;
    logic [3:0]       free_slots;
    logic [2:0]       fu_avail;
    logic [2:0]       out_valid;
    logic [2:0][63:0] out_data;
    logic [3:0]       count;
    logic             overflow;

    typedef struct {
        logic [2:0] mask;
        logic [3:0] cnt;
        logic [3:0] free;
        logic       ovf;
    } st_t;

    st_t         st_q[$];
    logic [63:0] dq[$];
    logic [63:0] model_q[$];
    bit          m_ovf;
    int          checks;
    int          errors;

    fu_issue_buffer #(
        .NUM_IN(2), .NUM_FU(3), .DEPTH(8), .DATA_W(64)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .squash(squash),
        .in_valid(in_valid),
        .in_data(in_data),
        .free_slots(free_slots),
        .fu_avail(fu_avail),
        .out_valid(out_valid),
        .out_data(out_data),
        .count(count),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Drive one cycle and advance the reference model across its edge
    task automatic step(input bit sq, input logic [1:0] v, input logic [2:0] av);
        logic [63:0] d [2];
        st_t         s;
        int          free;
        int          n;
        bit   [1:0]  used;
        @(negedge clk);
        d[0] = {$urandom, $urandom};
        d[1] = {$urandom, $urandom};
        squash     = sq;
        in_valid   = v;
        in_data[0] = d[0];
        in_data[1] = d[1];
        fu_avail   = av;
        free   = 8 - model_q.size();
        s.cnt  = 4'(model_q.size());
        s.free = 4'(free);
        s.ovf  = m_ovf;
        s.mask = '0;
        used   = '0;
        if ($countones(v) > free) m_ovf = 1'b1;
        if (sq) begin
            model_q.delete();
        end else begin
`ifdef FU_ISSUE_BUF_BYPASS_EN
            if (model_q.size() == 0) begin
                for (int i = 0; i < 3; i++) begin
                    bit found;
                    found = 1'b0;
                    for (int l = 0; l < 2; l++) begin
                        if (av[i] && !found && v[l] && !used[l]) begin
                            found     = 1'b1;
                            used[l]   = 1'b1;
                            s.mask[i] = 1'b1;
                            dq.push_back(d[l]);
                        end
                    end
                end
            end
`endif
            for (int i = 0; i < 3; i++) begin
                if (av[i] && model_q.size() > 0) begin
                    s.mask[i] = 1'b1;
                    dq.push_back(model_q.pop_front());
                end
            end
            n = 0;
            for (int l = 0; l < 2; l++) begin
                if (v[l] && !used[l] && n < free) begin
                    model_q.push_back(d[l]);
                    n++;
                end
            end
        end
        st_q.push_back(s);
    endtask

    // Random stimulus that honours the free_slots contract
    task automatic rstep(input logic [2:0] av);
        logic [1:0] v;
        int         free;
        bit         sq;
        v    = 2'($urandom);
        sq   = ($urandom % 16) == 0;
        free = 8 - model_q.size();
        if ($countones(v) > free) v = (free == 0) ? 2'b00 : 2'b10;
        step(sq, v, av);
    endtask

    // Monitor: compare whatever the DUT presents just before each edge
    always begin
        st_t s;
        @(negedge clk);
        #4;
        if (rst_n && st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("out_valid", 64'(out_valid), 64'(s.mask));
            chk("count", 64'(count), 64'(s.cnt));
            chk("free_slots", 64'(free_slots), 64'(s.free));
            chk("overflow", 64'(overflow), 64'(s.ovf));
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i]) begin
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fu%0d_data unexpected packet %h", i, out_data[i]);
                    end else begin
                        chk($sformatf("fu%0d_data", i), out_data[i], dq.pop_front());
                    end
                end else begin
                    chk($sformatf("fu%0d_idle_data", i), out_data[i], 64'd0);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        m_ovf    = 1'b0;
        rst_n    = 1'b0;
        squash   = 1'b0;
        in_valid = '0;
        in_data  = '0;
        fu_avail = '0;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_free", 64'(free_slots), 64'd8);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_out_data", 64'(out_data[0] | out_data[1] | out_data[2]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 2'b11, 3'b000);
        step(0, 2'b00, 3'b101);
        step(0, 2'b00, 3'b000);
        repeat (4) step(0, 2'b11, 3'b000);
        step(0, 2'b01, 3'b000);
        step(0, 2'b00, 3'b000);
        step(0, 2'b00, 3'b111);
        step(0, 2'b00, 3'b010);
        step(0, 2'b00, 3'b010);
        step(0, 2'b11, 3'b111);
        step(0, 2'b11, 3'b000);
        step(0, 2'b01, 3'b000);
        step(1, 2'b11, 3'b111);
        step(0, 2'b00, 3'b111);
        step(0, 2'b11, 3'b010);
        step(0, 2'b00, 3'b000);
        step(0, 2'b00, 3'b111);

        for (int i = 0; i < 300; i++) begin
            rstep((($urandom % 4) == 0) ? 3'($urandom) : 3'b000);
        end
        for (int i = 0; i < 300; i++) begin
            rstep(3'($urandom));
        end

        step(0, 2'b11, 3'b000);
        step(0, 2'b10, 3'b000);
        @(negedge clk);
        squash   = 1'b0;
        in_valid = '0;
        fu_avail = '0;
        #6;
        chk("scoreboard_drained", 64'(st_q.size()), 64'd0);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_free", 64'(free_slots), 64'd8);
        chk("async_rst_overflow", 64'(overflow), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        model_q.delete();
        dq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 2'b11, 3'b000);
        step(0, 2'b00, 3'b011);
        step(0, 2'b00, 3'b000);
        @(negedge clk);
        in_valid = '0;
        fu_avail = '0;
        #6;
        chk("final_drained", 64'(st_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_issue_buffer.md
Name: fu_issue_buffer

Overview:
- Age-ordered FIFO between RS issue/select and the FU/CDB stage (fu_cdb) for one FU class.
- Absorbs up to NUM_IN issued instructions per cycle.
- Each cycle, drains the oldest entries onto whichever FUs of that class assert their avail bits (alu_avail / mult_avail / load_avail / store_avail).
- Flushes on branch-mispredict squash.

Parameters:
- NUM_IN, 2, issue lanes accepted per cycle (matches `N).
- NUM_FU, 3, FUs of this class, one out port each.
- DEPTH, 8, buffer entries; power of two, >= NUM_IN.
- DATA_W, 64, opaque payload width (packed FU_PACKET).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- squash  in  1  flush all contents, synchronous.
- in_valid  in  NUM_IN  lane valid; lane 0 is oldest.
- in_data  in  NUM_IN x DATA_W  lane payloads.
- free_slots  out  $clog2(DEPTH+1)  DEPTH minus registered count.
- fu_avail  in  NUM_FU  FU can accept a packet this cycle.
- out_valid  out  NUM_FU  packet presented to FU i.
- out_data  out  NUM_FU x DATA_W  packet for FU i.
- count  out  $clog2(DEPTH+1)  occupied entries, registered.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, async): head=tail=count=0, overflow=0, all entry valids cleared. Outputs: free_slots=DEPTH, out_valid=0, out_data=0.
- Storage: DEPTH-entry circular array, head/tail pointers mod DEPTH, explicit count register.
- Enqueue:
  - Valid lanes are compacted in lane order and written at tail, tail+1, ... (wrap at DEPTH).
  - Valid lanes need not be contiguous; order is preserved.
  - Upstream contract: popcount(in_valid) <= free_slots of the same cycle.
  - free_slots is derived from the registered count only; same-cycle dequeues are not credited.
- Enqueue violation: only the first free_slots valid lanes are written, the rest are dropped, and overflow sets the next edge. overflow is cleared only by reset.
- Dequeue (combinational from registered state):
  - k = min(count, popcount(fu_avail)).
  - Entry head+j goes to the j-th set bit of fu_avail, scanning from index 0 upward.
  - out_valid is 1 only on those k FUs; out_data=0 where out_valid=0.
  - head += k and count -= k at the edge.
  - out_valid never asserts on an FU whose fu_avail=0.
- Latency: an entry enqueued at edge t is first visible on out_* in cycle t+1. Minimum latency is 1 cycle; the only exception is when the bypass feature is enabled.
- Simultaneous enqueue and dequeue: count_next = count + enq - k. Never exceeds DEPTH, given the upstream contract.
- Full: free_slots=0; all in_valid ignored (overflow sets if any in_valid is high).
- Empty: out_valid=0 regardless of fu_avail.
- Squash:
  - During the squash cycle, out_valid is forced 0 and enqueues are discarded.
  - At the edge: head=tail=count=0, entries invalidated. overflow is unaffected.
  - The cycle after squash presents an empty buffer.
- Reset asserted mid-operation drops all contents immediately, regardless of clock.

Optional Feature:
- Macro: FU_ISSUE_BUF_BYPASS_EN.
- Defined:
  - Applies only when count==0 and squash=0.
  - Valid input lanes go straight to available FUs in the same cycle (zero latency), using the same lowest-index mapping.
  - Lanes not consumed are enqueued in order.
  - free_slots semantics are unchanged.
- Undefined: no bypass path; inputs always take at least 1 cycle through storage.

Test Plan:
- Reset, then enqueue A, B (in_valid=2'b11) with fu_avail=0 -> next cycle count=2, free_slots=6, out_valid=0.
- From that state, fu_avail=3'b101 -> out_valid=3'b101, FU0=A, FU2=B; next cycle count=0.
- Fill 8 entries, then in_valid=2'b01 with free_slots=0 -> entry dropped, overflow=1 and stays 1 until reset; count stays 8.
- count=3, enqueue 2 while fu_avail=3'b111 -> 3 oldest out in order; next count=2; head/tail wrap correctly across index 7->0.
- Squash with count=5 and in_valid=2'b11 -> out_valid=0 that cycle; next cycle count=0, free_slots=8.
- With FU_ISSUE_BUF_BYPASS_EN, empty buffer, in_valid=2'b11, fu_avail=3'b010 -> lane0 on FU1 same cycle; lane1 enqueued, count=1 next cycle. Without the macro -> out_valid=0 same cycle, count=2.
